serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 14 +
 rtl/serial_add_sub_cell.sv | 24 ++
 rtl/serial_add_sub.sv | 124 ++++++++++++
 tb/tb_serial_add_sub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit:
// FSM state encoding and operation mode constants.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_cell.sv
// One-bit combinational add/subtract cell: full adder when mode is add,
// full subtractor (borrow out) when mode is subtract.
module full_add_sub_cell
  import serial_add_sub_pkg::*;
(
  input  logic mode,
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic d,
  output logic co
);

  // Sum/difference bit is identical for both modes; only carry vs borrow differs.
  always_comb begin
    d = x ^ y ^ ci;
    if (mode == MODE_SUB) begin
      co = (~x & y) | (~x & ci) | (y & ci);
    end else begin
      co = (x & y) | (ci & (x ^ y));
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract unit: one bit per clock, LSB first,
// through a single one-bit cell, with start/done handshake and signed overflow.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, s_q;
  logic             mode_q, carry_q, c_out_q, ovf_q;
  logic             cell_d, cell_co;

  full_add_sub_cell u_cell (
    .mode (mode_q),
    .x    (a_q[0]),
    .y    (b_q[0]),
    .ci   (carry_q),
    .d    (cell_d),
    .co   (cell_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, serial shift, and result capture on the MSB step.
  // Overflow compares carry into the MSB (carry_q) with carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            carry_q <= c_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          r_q     <= {cell_d, r_q[WIDTH-1:1]};
          carry_q <= cell_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            s_q     <= {cell_d, r_q[WIDTH-1:1]};
            c_out_q <= cell_co;
            ovf_q   <= carry_q ^ cell_co;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    s        = s_q;
    c_out    = c_out_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed, table-driven bench for serial_add_sub at WIDTH=8 and WIDTH=2.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, mode8, cin8, busy8, done8, c8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       start2, mode2, cin2, busy2, done2, c2, ovf2;
  logic [1:0] a2, b2, s2;

  int checks   = 0;
  int failures = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .c_in(cin8), .busy(busy8), .done(done8), .s(s8), .c_out(c8), .overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .c_in(cin2), .busy(busy2), .done(done2), .s(s2), .c_out(c2), .overflow(ovf2)
  );

  typedef struct {
    logic       md;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t v8[8];
  vec_t v2[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: wide integer arithmetic, independent of the serial datapath.
  function automatic logic [9:0] model8(input logic md, input logic [7:0] a, input logic [7:0] b,
                                        input logic ci);
    int ua, ub, sa, sb, ic, r, sr;
    logic c, o;
    ua = a; ub = b; ic = ci;
    sa = $signed(a); sb = $signed(b);
    if (!md) begin
      r = ua + ub + ic; c = (r >= 256); sr = sa + sb + ic;
    end else begin
      r = ua - ub - ic; c = (ua < ub + ic); sr = sa - sb - ic;
    end
    o = (sr > 127) || (sr < -128);
    return {o, c, r[7:0]};
  endfunction

  task automatic do_op8(input logic md, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    logic tok;
    @(negedge clk);
    mode8 = md; a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; mode8 = ~md; cin8 = ~ci;
    tok = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (busy8 !== 1'b1 || done8 !== (k == 9)) tok = 1'b0;
      if (k < 9) begin
        @(posedge clk); #1;
      end
    end
    chk({nm, "_timing"}, {31'd0, tok}, 32'd1);
    chk({nm, "_s"}, {24'd0, s8}, {24'd0, es});
    chk({nm, "_cout"}, {31'd0, c8}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
    @(posedge clk); #1;
    chk({nm, "_idle"}, {30'd0, busy8, done8}, 32'd0);
  endtask

  task automatic do_op2(input logic md, input logic [1:0] a, input logic [1:0] b, input logic ci,
                        input logic [1:0] es, input logic ec, input logic eo, input string nm);
    logic tok;
    @(negedge clk);
    mode2 = md; a2 = a; b2 = b; cin2 = ci; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = ~a; b2 = ~b; cin2 = ~ci;
    tok = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (busy2 !== 1'b1 || done2 !== (k == 3)) tok = 1'b0;
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    chk({nm, "_timing"}, {31'd0, tok}, 32'd1);
    chk({nm, "_s"}, {30'd0, s2}, {30'd0, es});
    chk({nm, "_bout"}, {31'd0, c2}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, ovf2}, {31'd0, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ha[30], hb[30];
    logic       hm[30], hc[30];
    logic [9:0] exp;
    logic       t5_ok, t6_ok;
    int         ndone;

    //             md    a      b      ci    s      c     o
    v8[0] = '{1'b0, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0};
    v8[1] = '{1'b0, 8'd100, 8'd28, 1'b0, 8'h80,  1'b0, 1'b1};
    v8[2] = '{1'b0, 8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0};
    v8[3] = '{1'b1, 8'd5,   8'd7,  1'b0, 8'hFE,  1'b1, 1'b0};
    v8[4] = '{1'b1, 8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1};
    v8[5] = '{1'b0, 8'h80,  8'h80, 1'b0, 8'h00,  1'b1, 1'b1};
    v8[6] = '{1'b1, 8'h00,  8'h00, 1'b1, 8'hFF,  1'b1, 1'b0};
    v8[7] = '{1'b1, 8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1};

    // WIDTH=2 subtract: full-subtractor truth table in the low bit
    v2[0] = '{1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    v2[1] = '{1'b1, 8'd0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0};
    v2[2] = '{1'b1, 8'd0, 8'd1, 1'b0, 8'd3, 1'b1, 1'b0};
    v2[3] = '{1'b1, 8'd0, 8'd1, 1'b1, 8'd2, 1'b1, 1'b0};
    v2[4] = '{1'b1, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    v2[5] = '{1'b1, 8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0};
    v2[6] = '{1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
    v2[7] = '{1'b1, 8'd1, 8'd1, 1'b1, 8'd3, 1'b1, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    start2 = 1'b0; mode2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl8", {30'd0, busy8, done8}, 32'd0);
    chk("reset_res8", {22'd0, ovf8, c8, s8}, 32'd0);
    chk("reset_ctl2", {26'd0, busy2, done2, ovf2, c2, s2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op8(v8[i].md, v8[i].a, v8[i].b, v8[i].ci, v8[i].s, v8[i].c, v8[i].o,
             $sformatf("w8_vec%0d", i));

    for (int i = 0; i < 8; i++)
      do_op2(v2[i].md, v2[i].a[1:0], v2[i].b[1:0], v2[i].ci, v2[i].s[1:0], v2[i].c, v2[i].o,
             $sformatf("w2_vec%0d", i));

    // start held high with fresh operands every cycle
    t5_ok = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ha[cyc] = 8'(cyc * 37 + 5);
      hb[cyc] = 8'(cyc * 11 + 200);
      hm[cyc] = 1'((cyc + cyc / 10) & 1);
      hc[cyc] = 1'((cyc % 3) == 1);
      start8 = 1'b1; a8 = ha[cyc]; b8 = hb[cyc]; mode8 = hm[cyc]; cin8 = hc[cyc];
      @(posedge clk); #1;
      if (done8 === 1'b1) ndone++;
      if (done8 !== ((cyc % 10) == 8)) t5_ok = 1'b0;
      if ((cyc % 10) == 8) begin
        exp = model8(hm[cyc-8], ha[cyc-8], hb[cyc-8], hc[cyc-8]);
        chk($sformatf("held_start_res%0d", cyc / 10), {22'd0, ovf8, c8, s8}, {22'd0, exp});
      end
    end
    start8 = 1'b0;
    chk("held_start_done_pattern", {31'd0, t5_ok}, 32'd1);
    chk("held_start_done_count", ndone, 32'd3);

    // reset mid-operation
    do_op8(v8[0].md, v8[0].a, v8[0].b, v8[0].ci, v8[0].s, v8[0].c, v8[0].o, "pre_abort");
    t6_ok = 1'b1;
    @(negedge clk);
    mode8 = 1'b0; a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (done8 !== 1'b0 || busy8 !== 1'b1) t6_ok = 1'b0;
    @(posedge clk); #1;
    if (done8 !== 1'b0) t6_ok = 1'b0;
    @(posedge clk); #1;
    if (done8 !== 1'b0) t6_ok = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctl", {30'd0, busy8, done8}, 32'd0);
    chk("abort_res", {22'd0, ovf8, c8, s8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    if (done8 !== 1'b0 || busy8 !== 1'b0) t6_ok = 1'b0;
    chk("abort_no_done", {31'd0, t6_ok}, 32'd1);
    do_op8(1'b0, 8'h55, 8'h22, 1'b1, 8'h78, 1'b0, 1'b0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
